fp_byte_deserializer: RTL



---
 rtl/fp_byte_deserializer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/fp_byte_deserializer.sv
// fp_byte_deserializer
// Input stage of the byte-serial double-precision multiplier. Gathers
// 2*WORD_BYTES bytes (LSB byte first, operand A then operand B) into OP_A and
// OP_B, presents them over a valid/ready handshake and freezes them until the
// core accepts. Bytes arriving while the pair is pending are dropped and
// flagged on the sticky OVERRUN output.
//
// Optional feature macro: FP_OPERAND_CLASS_EN
//   When defined, A_CLASS/B_CLASS report the IEEE-754 class of each operand
//   (0 zero, 1 subnormal, 2 normal, 3 infinity, 4 NaN). The classification
//   reads bits [62:52]/[51:0], so it assumes WORD_BYTES = 8.

module fp_byte_deserializer #(
   parameter int WORD_BYTES   = 8,
   parameter int IDLE_TIMEOUT = 0
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    ENABLE,
   input  logic [7:0]              DATA_IN,
   input  logic                    OP_READY,
   output logic [8*WORD_BYTES-1:0] OP_A,
   output logic [8*WORD_BYTES-1:0] OP_B,
   output logic                    OP_VALID,
   output logic                    BUSY,
`ifdef FP_OPERAND_CLASS_EN
   output logic [2:0]              A_CLASS,
   output logic [2:0]              B_CLASS,
`endif
   output logic                    OVERRUN
);

   localparam int W            = 8 * WORD_BYTES;
   localparam int CountWidth   = (2 * WORD_BYTES > 1) ? $clog2(2 * WORD_BYTES) : 1;
   localparam int TimeoutWidth = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

   localparam logic [CountWidth-1:0]   CountHalf = CountWidth'(WORD_BYTES);
   localparam logic [CountWidth-1:0]   CountLast = CountWidth'(2 * WORD_BYTES - 1);
   localparam logic [CountWidth-1:0]   CountOne  = CountWidth'(1);
   localparam logic [TimeoutWidth-1:0] IdleLast  = TimeoutWidth'(IDLE_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_HOLD
   } stateType;

   stateType state, stateNext;

   logic [CountWidth-1:0]   cnt, cntNext;
   logic [TimeoutWidth-1:0] idleCnt, idleNext;
   logic                    opValid, validNext;
   logic                    overrun, overrunNext;
   logic                    capture;
   logic [W-1:0]            opA, opB;
   logic [W-1:0]            opBShifted;

   // The byte on DATA_IN shifted in from the top; when this capture completes
   // the frame this is the final value of operand B, which the optional
   // classifier needs on the same edge that raises OP_VALID.
   assign opBShifted = {DATA_IN, opB[W-1:8]};

   // Control registers: FSM state, byte position within the frame, idle
   // counter, the valid flag and the sticky overrun flag all move together.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state   <= S_IDLE;
         cnt     <= '0;
         idleCnt <= '0;
         opValid <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state   <= stateNext;
         cnt     <= cntNext;
         idleCnt <= idleNext;
         opValid <= validNext;
         overrun <= overrunNext;
      end
   end

   // Next-state logic. IDLE waits for the first byte, COLLECT accepts bytes
   // (stalling on ENABLE low and optionally timing out a stuck partial frame),
   // HOLD freezes the pair until the handshake. A byte arriving on the very
   // handshake cycle starts the next frame so back-to-back frames need no
   // bubble; a byte arriving in HOLD without the handshake is lost.
   always_comb begin
      stateNext   = state;
      cntNext     = cnt;
      idleNext    = '0;
      capture     = 1'b0;
      validNext   = opValid;
      overrunNext = overrun;
      unique case (state)
         S_IDLE: begin
            if (ENABLE) begin
               capture   = 1'b1;
               cntNext   = CountOne;
               stateNext = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (ENABLE) begin
               capture = 1'b1;
               if (cnt == CountLast) begin
                  cntNext   = '0;
                  validNext = 1'b1;
                  stateNext = S_HOLD;
               end else begin
                  cntNext = cnt + 1'b1;
               end
            end else if (IDLE_TIMEOUT > 0) begin
               if (idleCnt == IdleLast) begin
                  cntNext   = '0;
                  stateNext = S_IDLE;
               end else begin
                  idleNext = idleCnt + 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (OP_READY) begin
               validNext = 1'b0;
               if (ENABLE) begin
                  capture   = 1'b1;
                  cntNext   = CountOne;
                  stateNext = S_COLLECT;
               end else begin
                  stateNext = S_IDLE;
               end
            end else if (ENABLE) begin
               overrunNext = 1'b1;
            end
         end
         default: begin
            stateNext = S_IDLE;
            cntNext   = '0;
         end
      endcase
   end

   // Operand shift registers double as the output registers. Captures only
   // happen outside HOLD (or on the handshake edge, which is the moment the
   // core gives the pair up), so the operands never move while OP_VALID is high.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         opA <= '0;
         opB <= '0;
      end else if (capture) begin
         if (cnt < CountHalf) begin
            opA <= {DATA_IN, opA[W-1:8]};
         end else begin
            opB <= opBShifted;
         end
      end
   end

`ifdef FP_OPERAND_CLASS_EN
   logic [2:0] classA, classB;

   function automatic logic [2:0] classify(input logic [10:0] exponent,
                                           input logic [51:0] fraction);
      if (exponent == 11'd0) begin
         classify = (fraction == 52'd0) ? 3'd0 : 3'd1;
      end else if (exponent == 11'h7FF) begin
         classify = (fraction == 52'd0) ? 3'd3 : 3'd4;
      end else begin
         classify = 3'd2;
      end
   endfunction

   // Classes are latched on the same edge that raises OP_VALID: A is already
   // complete, B is taken from the value being written on that edge.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         classA <= 3'd0;
         classB <= 3'd0;
      end else if (validNext && !opValid) begin
         classA <= classify(opA[62:52], opA[51:0]);
         classB <= classify(opBShifted[62:52], opBShifted[51:0]);
      end
   end

   assign A_CLASS = classA;
   assign B_CLASS = classB;
`endif

   assign OP_A     = opA;
   assign OP_B     = opB;
   assign OP_VALID = opValid;
   assign OVERRUN  = overrun;
   assign BUSY     = (state == S_COLLECT);

endmodule
